// File: rtl/rf_debug_ctl_if.sv
// Debug bridge bundle: halt control, request channel, response channel and
// the sticky error flag. The bridge is the master; the halt controller is the slave.
interface rf_debug_ctl_if;
  logic        dbg_halt_req;
  logic        dbg_halted;
  logic        dbg_req_valid;
  logic        dbg_req_ready;
  logic        dbg_req_we;
  logic [4:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata;
  logic        dbg_rsp_valid;
  logic        dbg_rsp_ready;
  logic [31:0] dbg_rsp_rdata;
  logic        dbg_err;

  modport master (
    output dbg_halt_req, dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
           dbg_rsp_ready,
    input  dbg_halted, dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_err
  );

  modport slave (
    input  dbg_halt_req, dbg_req_valid, dbg_req_we, dbg_req_addr, dbg_req_wdata,
           dbg_rsp_ready,
    output dbg_halted, dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata, dbg_err
  );
endinterface

// File: rtl/rf_debug_ctl.sv
// Debug halt controller and regfile port arbiter for the decode stage.
// Drains the pipeline with bubbles on a halt request, then lets the debug
// bridge read/write the regfile one request at a time.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   S_RUN    | core running, regfile ports pass WB / decode through
//   S_DRAIN  | bubbles injected while EX/MEM/WB empty out
//   S_HALTED | core frozen, debug owns regfile ports, request accepted
//   S_RSP    | response presented, held until the bridge takes it
module rf_debug_ctl #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  rf_debug_ctl_if.slave dbg,
  output logic        stall_f_o,
  output logic        stall_d_o,
  output logic        flush_e_o,
  input  logic        wb_we3_i,
  input  logic [4:0]  wb_a3_i,
  input  logic [31:0] wb_wd3_i,
  input  logic [4:0]  id_a1_i,
  output logic        rf_we3_o,
  output logic [4:0]  rf_a3_o,
  output logic [31:0] rf_wd3_o,
  output logic [4:0]  rf_a1_o,
  input  logic [31:0] rf_rd1_i
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_RSP} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        halted, req_ready, rsp_valid, stall;

  // State, drain counter, response data and sticky error registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and port ownership per state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    halted    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    stall     = 1'b0;
    rf_we3_o  = wb_we3_i;
    rf_a3_o   = wb_a3_i;
    rf_wd3_o  = wb_wd3_i;
    rf_a1_o   = id_a1_i;

    case (state_q)
      S_RUN: begin
        if (dbg.dbg_halt_req) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_LOAD;
          err_d   = 1'b0;
        end
      end

      // Drain runs to completion even if the halt request drops.
      S_DRAIN: begin
        stall = 1'b1;
        if (cnt_q == '0) state_d = S_HALTED;
        else             cnt_d   = cnt_q - CW'(1);
      end

      S_HALTED: begin
        halted    = 1'b1;
        stall     = 1'b1;
        req_ready = 1'b1;
        rf_a1_o   = dbg.dbg_req_addr;
        rf_we3_o  = dbg.dbg_req_valid & dbg.dbg_req_we & (dbg.dbg_req_addr != 5'd0);
        rf_a3_o   = dbg.dbg_req_addr;
        rf_wd3_o  = dbg.dbg_req_wdata;
        if (wb_we3_i) err_d = 1'b1;
        // A pending request is served before honouring a resume.
        if (dbg.dbg_req_valid) begin
          rdata_d = dbg.dbg_req_we ? 32'd0 : rf_rd1_i;
          state_d = S_RSP;
        end else if (!dbg.dbg_halt_req) begin
          state_d = S_RUN;
        end
      end

      S_RSP: begin
        halted    = 1'b1;
        stall     = 1'b1;
        rsp_valid = 1'b1;
        rf_we3_o  = 1'b0;
        rf_a3_o   = 5'd0;
        rf_wd3_o  = 32'd0;
        rf_a1_o   = dbg.dbg_req_addr;
        if (wb_we3_i) err_d = 1'b1;
        if (dbg.dbg_rsp_ready) state_d = S_HALTED;
      end

      default: state_d = S_RUN;
    endcase
  end

  assign stall_f_o         = stall;
  assign stall_d_o         = stall;
  assign flush_e_o         = stall;
  assign dbg.dbg_halted    = halted;
  assign dbg.dbg_req_ready = req_ready;
  assign dbg.dbg_rsp_valid = rsp_valid;
  assign dbg.dbg_rsp_rdata = rdata_q;
  assign dbg.dbg_err       = err_q;

endmodule
